cache_repl_ctrl: RTL and testbench

CACHE_REPL_CTRL -- requirements
Module: cache_repl_ctrl

---
 rtl/cache_repl_ctrl_pkg.sv | 23 ++
 rtl/cache_repl_ctrl_if.sv | 38 +++
 rtl/cache_repl_ctrl_victim_sel.sv | 38 +++
 rtl/cache_repl_ctrl.sv | 126 ++++++++++++
 tb/tb_cache_repl_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_repl_ctrl_pkg.sv
// Shared types and constants for the cache replacement controller.
// State encoding, bus widths and the line-alignment helper live here.
package cache_pkg;

  localparam int DEF_ENTRIES   = 4;
  localparam int DEF_LINE_BITS = 6;
  localparam int COUNT_W       = 12;
  localparam int PA_W          = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_VICTIM,
    ST_REFILL,
    ST_WRITE,
    ST_CLEAR
  } state_t;

  function automatic logic [PA_W-1:0] line_align(input logic [PA_W-1:0] pa, input int lb);
    return (pa >> lb) << lb;
  endfunction

endpackage

// File: rtl/cache_repl_ctrl_if.sv
// Lookup / entry-array / refill bundle between the controller (slave)
// and its surroundings (master).
interface cache_repl_ctrl_if import cache_pkg::*; #(
  parameter int ENTRIES = DEF_ENTRIES
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic                       lk_valid;
  logic [PA_W-1:0]            lk_pa;
  logic                       lk_ready;
  logic                       lk_done;
  logic                       lk_hit;
  logic [IDX_W-1:0]           lk_way;
  logic [PA_W*ENTRIES-1:0]    entry_pa;
  logic [ENTRIES-1:0]         entry_valid;
  logic [COUNT_W*ENTRIES-1:0] entry_count;
  logic [ENTRIES-1:0]         entry_write;
  logic [PA_W-1:0]            entry_pa_in;
  logic [ENTRIES-1:0]         entry_access;
  logic                       mem_req;
  logic [PA_W-1:0]            mem_pa;
  logic                       mem_ack;
  logic                       clear_req;
  logic                       l1_clear;

  modport master (
    output lk_valid, lk_pa, entry_pa, entry_valid, entry_count, mem_ack, clear_req,
    input  lk_ready, lk_done, lk_hit, lk_way, entry_write, entry_pa_in, entry_access,
           mem_req, mem_pa, l1_clear
  );

  modport slave (
    input  lk_valid, lk_pa, entry_pa, entry_valid, entry_count, mem_ack, clear_req,
    output lk_ready, lk_done, lk_hit, lk_way, entry_write, entry_pa_in, entry_access,
           mem_req, mem_pa, l1_clear
  );

endinterface

// File: rtl/cache_repl_ctrl_victim_sel.sv
// Combinational victim pick: lowest-index invalid entry, otherwise the
// least-frequently-used entry with ties going to the lowest index.
module cache_victim_sel import cache_pkg::*; #(
  parameter int ENTRIES = DEF_ENTRIES
) (
  input  logic [ENTRIES-1:0]         entry_valid_i,
  input  logic [COUNT_W*ENTRIES-1:0] entry_count_i,
  output logic [$clog2(ENTRIES)-1:0] victim_o
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic               free_any;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   min_idx;
  logic [COUNT_W-1:0] min_cnt;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    // Descending scan so the lowest free index is the one left standing.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid_i[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    min_idx = '0;
    min_cnt = entry_count_i[COUNT_W-1:0];
    for (int i = 1; i < ENTRIES; i++) begin
      if (entry_count_i[i*COUNT_W +: COUNT_W] < min_cnt) begin
        min_cnt = entry_count_i[i*COUNT_W +: COUNT_W];
        min_idx = IDX_W'(i);
      end
    end
    victim_o = free_any ? free_idx : min_idx;
  end

endmodule

// File: rtl/cache_repl_ctrl.sv
// Lookup / LFU-replacement sequencer: hit detect, victim pick, refill
// handshake, entry write-back and whole-array invalidate.
module cache_repl_ctrl import cache_pkg::*; #(
  parameter int ENTRIES   = DEF_ENTRIES,
  parameter int LINE_BITS = DEF_LINE_BITS
) (
  input logic              clk,
  input logic              rst,
  cache_repl_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [ENTRIES-1:0] ONE_HOT = {{(ENTRIES-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [PA_W-1:0]    pa_q;
  logic [IDX_W-1:0]   victim_q;
  logic               lk_done_q;
  logic               lk_hit_q;
  logic [IDX_W-1:0]   lk_way_q;
  logic [ENTRIES-1:0] entry_write_q;
  logic [ENTRIES-1:0] entry_access_q;
  logic [PA_W-1:0]    entry_pa_in_q;
  logic               mem_req_q;
  logic [PA_W-1:0]    mem_pa_q;
  logic               l1_clear_q;

  logic               hit_any;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   victim_pick;

  // Tag compare runs on the request as it is accepted so the hit result
  // is already registered and presented during the LOOKUP cycle.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (bus.entry_valid[i] &&
          (((bus.entry_pa[i*PA_W +: PA_W] ^ bus.lk_pa) >> LINE_BITS) == '0)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  cache_victim_sel #(.ENTRIES(ENTRIES)) u_victim_sel (
    .entry_valid_i (bus.entry_valid),
    .entry_count_i (bus.entry_count),
    .victim_o      (victim_pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      pa_q           <= '0;
      victim_q       <= '0;
      lk_done_q      <= 1'b0;
      lk_hit_q       <= 1'b0;
      lk_way_q       <= '0;
      entry_write_q  <= '0;
      entry_access_q <= '0;
      entry_pa_in_q  <= '0;
      mem_req_q      <= 1'b0;
      mem_pa_q       <= '0;
      l1_clear_q     <= 1'b0;
    end else begin
      lk_done_q      <= 1'b0;
      lk_hit_q       <= 1'b0;
      lk_way_q       <= '0;
      entry_write_q  <= '0;
      entry_access_q <= '0;
      entry_pa_in_q  <= '0;
      l1_clear_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.clear_req) begin
            state_q    <= ST_CLEAR;
            l1_clear_q <= 1'b1;
          end else if (bus.lk_valid) begin
            state_q <= ST_LOOKUP;
            pa_q    <= bus.lk_pa;
            if (hit_any) begin
              lk_done_q      <= 1'b1;
              lk_hit_q       <= 1'b1;
              lk_way_q       <= hit_idx;
              entry_access_q <= ONE_HOT << hit_idx;
            end
          end
        end
        ST_LOOKUP: state_q <= lk_hit_q ? ST_IDLE : ST_VICTIM;
        ST_VICTIM: begin
          state_q   <= ST_REFILL;
          victim_q  <= victim_pick;
          mem_req_q <= 1'b1;
          mem_pa_q  <= line_align(pa_q, LINE_BITS);
        end
        ST_REFILL: begin
          if (bus.mem_ack) begin
            state_q        <= ST_WRITE;
            mem_req_q      <= 1'b0;
            mem_pa_q       <= '0;
            entry_write_q  <= ONE_HOT << victim_q;
            entry_pa_in_q  <= line_align(pa_q, LINE_BITS);
            lk_done_q      <= 1'b1;
            lk_way_q       <= victim_q;
            entry_access_q <= ONE_HOT << victim_q;
          end
        end
        ST_WRITE: state_q <= ST_IDLE;
        ST_CLEAR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.lk_ready     = rst && (state_q == ST_IDLE) && !bus.clear_req;
  assign bus.lk_done      = lk_done_q;
  assign bus.lk_hit       = lk_hit_q;
  assign bus.lk_way       = lk_way_q;
  assign bus.entry_write  = entry_write_q;
  assign bus.entry_access = entry_access_q;
  assign bus.entry_pa_in  = entry_pa_in_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_pa       = mem_pa_q;
  assign bus.l1_clear     = l1_clear_q;

endmodule

// File: tb/tb_cache_repl_ctrl.sv
// Self-checking bench for cache_repl_ctrl: directed scenarios plus random
// lookups checked against a behavioural entry-array model.
module tb_cache_repl_ctrl;
  import cache_pkg::*;

  localparam int N  = 4;
  localparam int LB = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_repl_ctrl_if #(.ENTRIES(N)) bus();
  cache_repl_ctrl #(.ENTRIES(N), .LINE_BITS(LB)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] m_pa    [N];
  logic        m_valid [N];
  logic [11:0] m_cnt   [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.entry_pa[g*64 +: 64]    = m_pa[g];
    assign bus.entry_valid[g]          = m_valid[g];
    assign bus.entry_count[g*12 +: 12] = m_cnt[g];
  end

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int exp_hit(input logic [63:0] pa);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && (m_pa[i] >> LB) == (pa >> LB)) return i;
    return -1;
  endfunction

  function automatic int exp_victim();
    int best;
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    best = 0;
    for (int i = 1; i < N; i++) if (m_cnt[i] < m_cnt[best]) best = i;
    return best;
  endfunction

  task automatic wait_cyc();
    @(posedge clk); #1;
  endtask

  // Full lookup from an IDLE cycle (called at posedge+1).
  task automatic do_lookup(input logic [63:0] pa, input int ack_dly, input bit clr_in_refill,
                           input bit ack_early, input string tag);
    int hi, vi;
    logic [63:0] ap;
    logic [N-1:0] oh;
    logic [1:0] way;
    hi = exp_hit(pa);
    ap = {pa[63:LB], {LB{1'b0}}};
    n_tests++;
    if (bus.lk_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_idle: got %b exp 1", tag, bus.lk_ready);
    end
    bus.lk_valid = 1'b1; bus.lk_pa = pa;
    wait_cyc();
    bus.lk_valid = 1'b0; bus.lk_pa = {$urandom, $urandom};
    oh = '0;
    if (hi >= 0) begin
      oh[hi] = 1'b1; way = 2'(hi);
      n_tests++;
      if ({bus.lk_done, bus.lk_hit, bus.lk_way, bus.entry_access, bus.entry_write, bus.mem_req}
          !== {1'b1, 1'b1, way, oh, 4'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s hit: got done=%b hit=%b way=%0d acc=%b wr=%b req=%b exp way=%0d acc=%b",
                 tag, bus.lk_done, bus.lk_hit, bus.lk_way, bus.entry_access, bus.entry_write,
                 bus.mem_req, way, oh);
      end
      if (m_cnt[hi] != 12'hFFF) m_cnt[hi] = m_cnt[hi] + 12'd1;
      wait_cyc();
    end else begin
      vi = exp_victim(); oh[vi] = 1'b1; way = 2'(vi);
      n_tests++;
      if ({bus.lk_done, bus.lk_ready, bus.mem_req} !== 3'b000) begin
        n_fail++; $display("FAIL %s miss_lookup: got done=%b ready=%b req=%b exp 000",
                           tag, bus.lk_done, bus.lk_ready, bus.mem_req);
      end
      wait_cyc();
      if (ack_early) bus.mem_ack = 1'b1;
      wait_cyc();
      bus.mem_ack = 1'b0;
      if (clr_in_refill) bus.clear_req = 1'b1;
      n_tests++;
      if ({bus.mem_req, bus.mem_pa, bus.lk_ready, bus.entry_write} !== {1'b1, ap, 1'b0, 4'b0}) begin
        n_fail++; $display("FAIL %s refill: got req=%b pa=%h ready=%b wr=%b exp pa=%h",
                           tag, bus.mem_req, bus.mem_pa, bus.lk_ready, bus.entry_write, ap);
      end
      repeat (ack_dly) wait_cyc();
      n_tests++;
      if ({bus.mem_req, bus.mem_pa} !== {1'b1, ap}) begin
        n_fail++; $display("FAIL %s refill_hold: got req=%b pa=%h exp pa=%h",
                           tag, bus.mem_req, bus.mem_pa, ap);
      end
      bus.mem_ack = 1'b1;
      wait_cyc();
      bus.mem_ack = 1'b0;
      n_tests++;
      if ({bus.entry_write, bus.entry_pa_in, bus.lk_done, bus.lk_hit, bus.lk_way,
           bus.entry_access, bus.mem_req, bus.mem_pa}
          !== {oh, ap, 1'b1, 1'b0, way, oh, 1'b0, 64'h0}) begin
        n_fail++;
        $display("FAIL %s write: got wr=%b pa_in=%h done=%b hit=%b way=%0d acc=%b req=%b mpa=%h exp wr=%b pa_in=%h way=%0d",
                 tag, bus.entry_write, bus.entry_pa_in, bus.lk_done, bus.lk_hit, bus.lk_way,
                 bus.entry_access, bus.mem_req, bus.mem_pa, oh, ap, way);
      end
      m_pa[vi] = ap; m_valid[vi] = 1'b1; m_cnt[vi] = 12'd1;
      wait_cyc();
      if (clr_in_refill) begin
        n_tests++;
        if ({bus.l1_clear, bus.lk_ready, bus.lk_done} !== 3'b000) begin
          n_fail++; $display("FAIL %s clr_wait_idle: got clr=%b ready=%b done=%b exp 000",
                             tag, bus.l1_clear, bus.lk_ready, bus.lk_done);
        end
        wait_cyc();
        n_tests++;
        if ({bus.l1_clear, bus.lk_ready, bus.entry_write} !== {1'b1, 1'b0, 4'b0}) begin
          n_fail++; $display("FAIL %s clr_pulse: got clr=%b ready=%b wr=%b exp clr=1 ready=0",
                             tag, bus.l1_clear, bus.lk_ready, bus.entry_write);
        end
        bus.clear_req = 1'b0;
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        wait_cyc();
      end
    end
    n_tests++;
    if ({bus.lk_done, bus.entry_write, bus.entry_access, bus.l1_clear, bus.lk_ready}
        !== {1'b0, 4'b0, 4'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL %s back_idle: got done=%b wr=%b acc=%b clr=%b ready=%b",
                         tag, bus.lk_done, bus.entry_write, bus.entry_access, bus.l1_clear, bus.lk_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({bus.lk_ready, bus.lk_done, bus.mem_req, bus.l1_clear, bus.entry_write, bus.mem_pa}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 64'h0}) begin
      n_fail++; $display("FAIL reset_hold: got ready=%b done=%b req=%b clr=%b wr=%b",
                         bus.lk_ready, bus.lk_done, bus.mem_req, bus.l1_clear, bus.entry_write);
    end
    rst = 1'b1;
    wait_cyc();
    n_tests++;
    if ({bus.lk_ready, bus.lk_done, bus.lk_way, bus.mem_req, bus.entry_access}
        !== {1'b1, 1'b0, 2'b0, 1'b0, 4'b0}) begin
      n_fail++; $display("FAIL reset_release: got ready=%b done=%b way=%0d req=%b acc=%b exp ready=1",
                         bus.lk_ready, bus.lk_done, bus.lk_way, bus.mem_req, bus.entry_access);
    end
  endtask

  task automatic test_hit();
    for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_pa[i] = '0; m_cnt[i] = '0; end
    m_valid[2] = 1'b1; m_pa[2] = 64'h1000; m_cnt[2] = 12'd5;
    do_lookup(64'h1024, 0, 1'b0, 1'b0, "hit_e2");
  endtask

  task automatic test_miss_free();
    m_valid[0] = 1'b1; m_pa[0] = 64'h2000;
    m_valid[1] = 1'b1; m_pa[1] = 64'h3000;
    m_valid[2] = 1'b0; m_valid[3] = 1'b0;
    do_lookup(64'h8000, 5, 1'b0, 1'b1, "miss_free");
  endtask

  task automatic test_lfu();
    logic [11:0] c [N] = '{12'd7, 12'd3, 12'd3, 12'd9};
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b1; m_pa[i] = 64'h10000 + 64'(i) * 64'h100; m_cnt[i] = c[i];
    end
    do_lookup(64'h9000, 2, 1'b0, 1'b0, "lfu_tie");
    for (int i = 0; i < N; i++) m_cnt[i] = 12'hFFF;
    do_lookup(64'hA040, 1, 1'b0, 1'b0, "lfu_sat_tie");
  endtask

  task automatic test_clear_priority();
    bus.clear_req = 1'b1; bus.lk_valid = 1'b1; bus.lk_pa = 64'h1000;
    #1;
    n_tests++;
    if (bus.lk_ready !== 1'b0) begin
      n_fail++; $display("FAIL clr_prio_ready: got %b exp 0", bus.lk_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({bus.l1_clear, bus.lk_ready, bus.lk_done} !== 3'b100) begin
      n_fail++; $display("FAIL clr_prio_pulse: got clr=%b ready=%b done=%b exp 100",
                         bus.l1_clear, bus.lk_ready, bus.lk_done);
    end
    bus.clear_req = 1'b0;
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    wait_cyc();
    n_tests++;
    if ({bus.l1_clear, bus.lk_done} !== 2'b00) begin
      n_fail++; $display("FAIL clr_prio_after: got clr=%b done=%b exp 00", bus.l1_clear, bus.lk_done);
    end
    do_lookup(64'h1000, 0, 1'b0, 1'b0, "clr_prio_lookup");
  endtask

  task automatic test_clear_in_refill();
    do_lookup(64'hC0DE_0000, 3, 1'b1, 1'b0, "clr_refill");
  endtask

  task automatic test_reset_refill();
    bus.lk_valid = 1'b1; bus.lk_pa = 64'hDEAD_0000;
    wait_cyc();
    bus.lk_valid = 1'b0;
    wait_cyc();
    wait_cyc();
    n_tests++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_refill_pre: got req=%b exp 1", bus.mem_req);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_req, bus.mem_pa, bus.entry_write, bus.lk_ready} !== {1'b0, 64'h0, 4'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_refill_async: got req=%b pa=%h wr=%b ready=%b exp all 0",
                         bus.mem_req, bus.mem_pa, bus.entry_write, bus.lk_ready);
    end
    #3 rst = 1'b1;
    bus.mem_ack = 1'b1;
    wait_cyc();
    bus.mem_ack = 1'b0;
    n_tests++;
    if ({bus.entry_write, bus.lk_done, bus.mem_req, bus.lk_ready} !== {4'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rst_refill_after: got wr=%b done=%b req=%b ready=%b exp ready=1 only",
                         bus.entry_write, bus.lk_done, bus.mem_req, bus.lk_ready);
    end
  endtask

  task automatic test_random();
    logic [63:0] pa;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b1; m_pa[i] = 64'h7000_0000_0000_0000 + 64'(i) * 64'h40; m_cnt[i] = 12'hFFF;
    end
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0)
          m_cnt[i] = ($urandom_range(0, 1) == 0) ? 12'hFFF : 12'($urandom_range(0, 4));
        if ($urandom_range(0, 9) == 0) m_valid[i] = 1'b0;
      end
      pa = 64'h7000_0000_0000_0000 + 64'($urandom_range(0, 5)) * 64'h40 + 64'($urandom_range(0, 63));
      do_lookup(pa, int'($urandom_range(0, 4)), 1'b0, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lk_valid = 1'b0; bus.lk_pa = '0; bus.mem_ack = 1'b0; bus.clear_req = 1'b0;
    for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_pa[i] = '0; m_cnt[i] = '0; end
    test_reset();
    test_hit();
    test_miss_free();
    test_lfu();
    test_clear_priority();
    test_clear_in_refill();
    test_reset_refill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
